// File: rtl/instr_fetch_queue_if.sv
// Fetch-queue bundle: ROM request/response on one side, instruction delivery
// and redirect on the other.
interface instr_fetch_queue_if;
    logic        oROM_CE;
    logic        oROM_RD;
    logic [7:0]  oROM_ADDR;
    logic [31:0] iROM_DATA;
    logic        oIR_VALID;
    logic [31:0] oIR;
    logic [7:0]  oPC;
    logic        iIR_READY;
    logic        iREDIRECT;
    logic [7:0]  iREDIRECT_PC;
    logic [3:0]  oCOUNT;

    modport master (
        output oROM_CE, oROM_RD, oROM_ADDR, oIR_VALID, oIR, oPC, oCOUNT,
        input  iROM_DATA, iIR_READY, iREDIRECT, iREDIRECT_PC
    );

    modport slave (
        input  oROM_CE, oROM_RD, oROM_ADDR, oIR_VALID, oIR, oPC, oCOUNT,
        output iROM_DATA, iIR_READY, iREDIRECT, iREDIRECT_PC
    );
endinterface

// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: issues ROM reads ahead of the core, buffers
// {pc, ir} pairs in a circular queue and flushes on redirect.
module instr_fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    instr_fetch_queue_if.master   bus
);

    localparam int          PTR_W = $clog2(DEPTH);
    localparam logic [31:0] NOP   = 32'h00000013;

    logic [7:0]       fetch_pc;
    logic             vld_p1;
    logic [7:0]       pc_p1;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [3:0]       count;
    logic [7:0]       pc_mem [DEPTH];
    logic [31:0]      ir_mem [DEPTH];

    logic             issue;
    logic             push;
    logic             pop;
    logic             head_vld;
    logic [4:0]       occupancy;
    logic [7:0]       redirect_pc;

    // Reserving a slot for the in-flight word keeps every response landing in free space.
    assign occupancy   = {1'b0, count} + {4'b0000, vld_p1};
    assign issue       = !iRST && !bus.iREDIRECT && (occupancy < 5'(DEPTH));
    assign head_vld    = !iRST && (count != 4'd0);
    assign pop         = head_vld && bus.iIR_READY && !bus.iREDIRECT;
    assign push        = vld_p1 && !iRST && !bus.iREDIRECT;
    assign redirect_pc = bus.iREDIRECT_PC & 8'hFC;

    assign bus.oROM_RD   = issue;
    assign bus.oROM_CE   = issue;
    assign bus.oROM_ADDR = {2'b00, fetch_pc[7:2]};
    assign bus.oIR_VALID = head_vld;
    assign bus.oIR       = head_vld ? ir_mem[rd_ptr] : NOP;
    assign bus.oPC       = head_vld ? pc_mem[rd_ptr] : 8'h00;
    assign bus.oCOUNT    = iRST ? 4'd0 : count;

    // p0 -> p1: request issued, response expected next cycle
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            fetch_pc <= RESET_PC;
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= 4'd0;
        end else if (bus.iREDIRECT) begin
            fetch_pc <= redirect_pc;
            vld_p1   <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= 4'd0;
        end else begin
            vld_p1 <= issue;
            if (issue)
                fetch_pc <= fetch_pc + 8'd4;
            if (push)
                wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + 4'(push) - 4'(pop);
        end
    end

    // p1 -> queue: capture returning word with its pc tag
    always_ff @(posedge iCLK) begin
        if (issue)
            pc_p1 <= fetch_pc;
        if (push) begin
            pc_mem[wr_ptr] <= pc_p1;
            ir_mem[wr_ptr] <= bus.iROM_DATA;
        end
    end

endmodule
